// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding,
// base opcodes and the {pc, instr} queue entry layout.
package instr_fetch_queue_pkg;

    localparam int IFQ_XLEN = 32;
    localparam int IFQ_DEPTH = 8;

    localparam logic [IFQ_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO holding fetched {pc, instr} pairs.
// Ports: clk, rst_n, push/pop/flush, wdata in, rdata head out
// (zero when empty), count (0..DEPTH), full.
module fetch_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset: rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = (count != '0) ? mem[rd_ptr] : '0;
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads imem one word per cycle and
// queues {pc, instr} toward decode; redirects flush and restart.
// Ports: clk, rst_n, fetch_en, imem_addr/imem_rdata,
// redirect_valid/redirect_pc, dec_valid/dec_ready/dec_instr/dec_pc,
// q_count.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int             DEPTH    = IFQ_DEPTH,
    parameter logic [31:0]    RESET_PC = 32'h0,
    parameter int             XLEN     = IFQ_XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [XLEN-1:0]          dec_instr,
    output logic [XLEN-1:0]          dec_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_nxt;
    logic              push;
    logic              pop;
    logic              full;
    logic [2*XLEN-1:0] head;

    // Full is judged on the registered count; a same-cycle
    // pop does not open a slot for this cycle's push.
    assign push = fetch_en && !full && !redirect_valid;
    assign dec_valid = (q_count != '0) && !redirect_valid;
    assign pop  = dec_valid && dec_ready;

    always_comb begin
        pc_nxt = pc;
        unique case (1'b1)
            redirect_valid: pc_nxt = redirect_pc;
            push:           pc_nxt = pc + XLEN'(4);
            default:        pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= XLEN'(RESET_PC);
        end else begin
            pc <= pc_nxt;
        end
    end

    assign imem_addr = pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({pc, imem_rdata}),
        .rdata (head),
        .count (q_count),
        .full  (full)
    );

    assign dec_pc    = head[2*XLEN-1:XLEN];
    assign dec_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: queue-based model
// compared every cycle plus directed literal checkpoints.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [3:0]  q_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    int          msize;
    bit          mpop;
    bit          mpush;
    ent_t        ment;

    instr_fetch_queue #(
        .DEPTH    (8),
        .RESET_PC (32'h0),
        .XLEN     (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .q_count        (q_count)
    );

    // Instruction memory: word at address A reads as A + 0x100.
    assign imem_rdata = imem_addr + 32'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: in-order queue with capacity 8.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc = 32'h0;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = redirect_pc;
        end else begin
            msize = mq.size();
            mpop  = (msize != 0) && dec_ready;
            mpush = fetch_en && (msize < 8);
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                ment.pc    = mpc;
                ment.instr = mpc + 32'h100;
                mq.push_back(ment);
                mpc = mpc + 32'h4;
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            chk("m_valid", {31'b0, dec_valid},
                {31'b0, (mq.size() != 0) && !redirect_valid});
            chk("m_count", {28'b0, q_count}, 32'(mq.size()));
            chk("m_addr", imem_addr, mpc);
            if (mq.size() == 0) begin
                chk("m_pc_empty", dec_pc, 32'h0);
                chk("m_instr_empty", dec_instr, 32'h0);
            end else if (!redirect_valid) begin
                chk("m_pc", dec_pc, mq[0].pc);
                chk("m_instr", dec_instr, mq[0].instr);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        chk("rst_valid", {31'b0, dec_valid}, 32'h0);
        chk("rst_count", {28'b0, q_count}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        cyc(2);
        rst_n = 1'b1;

        // Streaming with decode always ready.
        cyc(1);
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        cyc(4);
        #2;
        chk("stream_pc", dec_pc, 32'hC);
        chk("stream_instr", dec_instr, 32'h10C);
        chk("stream_count", {28'b0, q_count}, 32'h1);

        // Asynchronous reset mid-cycle while handshaking.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, dec_valid}, 32'h0);
        chk("mid_rst_count", {28'b0, q_count}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        cyc(1);
        rst_n     = 1'b1;
        dec_ready = 1'b0;
        fetch_en  = 1'b1;

        // Fill under backpressure.
        cyc(12);
        #2;
        chk("fill_count", {28'b0, q_count}, 32'h8);
        chk("fill_addr", imem_addr, 32'h20);
        chk("fill_head", dec_pc, 32'h0);
        cyc(1);
        dec_ready = 1'b1;
        cyc(1);
        #2;
        chk("drain1_count", {28'b0, q_count}, 32'h7);
        chk("drain1_head", dec_pc, 32'h4);
        chk("drain1_addr", imem_addr, 32'h20);
        cyc(1);
        #2;
        chk("drain2_count", {28'b0, q_count}, 32'h7);
        chk("drain2_head", dec_pc, 32'h8);
        chk("drain2_addr", imem_addr, 32'h24);

        // Shrink to 5 entries, then redirect.
        cyc(1);
        fetch_en = 1'b0;
        cyc(2);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        #2;
        chk("redir_valid", {31'b0, dec_valid}, 32'h0);
        chk("redir_count_pre", {28'b0, q_count}, 32'h5);
        cyc(1);
        redirect_valid = 1'b0;
        #2;
        chk("redir_count", {28'b0, q_count}, 32'h0);
        chk("redir_addr", imem_addr, 32'h400);
        cyc(1);
        #2;
        chk("redir_first_pc", dec_pc, 32'h400);
        chk("redir_first_instr", dec_instr, 32'h500);

        // Redirect with a full queue and decode ready.
        cyc(1);
        dec_ready = 1'b0;
        cyc(9);
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h900;
        #2;
        chk("full_redir_count", {28'b0, q_count}, 32'h8);
        chk("full_redir_valid", {31'b0, dec_valid}, 32'h0);
        cyc(1);
        redirect_pc = 32'hA00;
        #2;
        chk("b2b_count", {28'b0, q_count}, 32'h0);
        chk("b2b_valid", {31'b0, dec_valid}, 32'h0);
        cyc(1);
        redirect_valid = 1'b0;
        #2;
        chk("b2b_addr", imem_addr, 32'hA00);

        // PC wrap at the top of the address space.
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cyc(1);
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        cyc(3);
        fetch_en  = 1'b0;
        dec_ready = 1'b1;
        #2;
        chk("wrap_count", {28'b0, q_count}, 32'h3);
        chk("wrap_pc0", dec_pc, 32'hFFFF_FFF8);
        chk("wrap_addr0", imem_addr, 32'h4);
        cyc(1);
        #2;
        chk("wrap_pc1", dec_pc, 32'hFFFF_FFFC);
        chk("wrap_addr1", imem_addr, 32'h4);
        cyc(1);
        #2;
        chk("wrap_pc2", dec_pc, 32'h0);
        chk("wrap_instr2", dec_instr, 32'h100);
        cyc(1);
        #2;
        chk("wrap_empty", {31'b0, dec_valid}, 32'h0);
        chk("wrap_addr3", imem_addr, 32'h4);

        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
